fib_stack_engine: RTL and testbench

//  Parametrised recursive Fibonacci engine: evaluates F(n) by explicit call/return over an internal frame stack.

---
 rtl/fib_stack_engine.sv | 151 +++++++++++++++
 tb/tb_fib_stack_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_stack_engine.sv
// Recursive Fibonacci engine: F(n) evaluated by explicit call/return over an
// internal frame stack, with overflow abort, sticky carry flag and depth peak.
module fib_stack_engine #(
    parameter int N_W   = 8,
    parameter int RES_W = 16,
    parameter int DEPTH = 32,
    localparam int MD_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N_W-1:0]   n_in,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] result,
    output logic             ovf,
    output logic             stack_err,
    output logic [MD_W-1:0]  max_depth
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = N_W + 1 + RES_W;

    typedef enum logic [1:0] {S_IDLE, S_CALL, S_RET, S_DONE} state_t;

    state_t             state_q;
    logic [N_W-1:0]     a_q;
    logic [RES_W-1:0]   ret_q;
    logic [MD_W-1:0]    sp_q;
    logic               busy_q, done_q, ovf_q, err_q;
    logic [RES_W-1:0]   result_q;
    logic [MD_W-1:0]    max_depth_q;

    // Frame layout: {n, phase, partial}; phase 1 means the left call has returned.
    logic [FW-1:0]      stack_mem [DEPTH];

    logic [MD_W-1:0]    sp_m1_d;
    logic [AW-1:0]      top_idx_d;
    logic [FW-1:0]      top_d;
    logic [N_W-1:0]     top_n_d;
    logic               top_ph_d;
    logic [RES_W-1:0]   top_part_d;
    logic [RES_W:0]     sum_d;
    logic               is_base_d, full_d;
    logic               push_d, rewrite_d;
    logic [AW-1:0]      wr_idx_d;
    logic [FW-1:0]      wr_data_d;

    assign sp_m1_d    = sp_q - MD_W'(1);
    assign top_idx_d  = AW'(sp_m1_d);
    assign top_d      = stack_mem[top_idx_d];
    assign top_n_d    = top_d[FW-1 -: N_W];
    assign top_ph_d   = top_d[RES_W];
    assign top_part_d = top_d[RES_W-1:0];
    assign sum_d      = {1'b0, top_part_d} + {1'b0, ret_q};
    assign is_base_d  = a_q < N_W'(2);
    assign full_d     = sp_q == MD_W'(DEPTH);

    assign push_d    = (state_q == S_CALL) && !is_base_d && !full_d;
    assign rewrite_d = (state_q == S_RET) && (sp_q != '0) && !top_ph_d;
    assign wr_idx_d  = push_d ? AW'(sp_q) : top_idx_d;
    assign wr_data_d = push_d ? {a_q, 1'b0, {RES_W{1'b0}}} : {top_n_d, 1'b1, ret_q};

    // Frame storage has no reset; only occupied entries are ever read.
    always_ff @(posedge clk) begin
        if (rst_n && (push_d || rewrite_d)) begin
            stack_mem[wr_idx_d] <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            ret_q       <= '0;
            sp_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= '0;
            max_depth_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q         <= n_in;
                        sp_q        <= '0;
                        ovf_q       <= 1'b0;
                        err_q       <= 1'b0;
                        max_depth_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_CALL;
                    end
                end
                S_CALL: begin
                    if (is_base_d) begin
                        ret_q   <= {{(RES_W-1){1'b0}}, a_q[0]};
                        state_q <= S_RET;
                    end else if (full_d) begin
                        err_q    <= 1'b1;
                        result_q <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        sp_q <= sp_q + MD_W'(1);
                        if (sp_q + MD_W'(1) > max_depth_q) begin
                            max_depth_q <= sp_q + MD_W'(1);
                        end
                        a_q <= a_q - N_W'(1);
                    end
                end
                S_RET: begin
                    if (sp_q == '0) begin
                        result_q <= ret_q;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else if (!top_ph_d) begin
                        // Left branch finished; descend into F(n-2).
                        a_q     <= top_n_d - N_W'(2);
                        state_q <= S_CALL;
                    end else begin
                        ret_q <= sum_d[RES_W-1:0];
                        if (sum_d[RES_W]) begin
                            ovf_q <= 1'b1;
                        end
                        sp_q <= sp_m1_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign stack_err = err_q;
    assign max_depth = max_depth_q;

endmodule

// File: tb/tb_fib_stack_engine.sv
// Bench for fib_stack_engine: three instances (default, 8-bit result, depth 4)
// checked every cycle against a Fibonacci/latency model plus literal vectors.
module tb_fib_stack_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0] start;
    logic [7:0] nin [3];
    wire  [2:0] busy_v, done_v, ovf_v, err_v;
    wire  [15:0] r0, r2;
    wire  [7:0]  r1;
    wire  [5:0]  m0, m1;
    wire  [2:0]  m2;

    fib_stack_engine #(.N_W(8), .RES_W(16), .DEPTH(32)) u_main (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .n_in(nin[0]),
        .busy(busy_v[0]), .done(done_v[0]), .result(r0), .ovf(ovf_v[0]),
        .stack_err(err_v[0]), .max_depth(m0));
    fib_stack_engine #(.N_W(8), .RES_W(8), .DEPTH(32)) u_narrow (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .n_in(nin[1]),
        .busy(busy_v[1]), .done(done_v[1]), .result(r1), .ovf(ovf_v[1]),
        .stack_err(err_v[1]), .max_depth(m1));
    fib_stack_engine #(.N_W(8), .RES_W(16), .DEPTH(4)) u_shallow (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .n_in(nin[2]),
        .busy(busy_v[2]), .done(done_v[2]), .result(r2), .ovf(ovf_v[2]),
        .stack_err(err_v[2]), .max_depth(m2));

    int n_checks = 0;
    int n_errors = 0;

    // Model state per instance: 0 idle, 1 running (cycles counted from accept).
    int     m_st [3];
    int     m_cnt [3];
    int     m_lat [3];
    longint m_res [3], m_ovf [3], m_err [3], m_md [3];
    longint p_res [3], p_ovf [3], p_err [3], p_md [3];

    function automatic int res_w_of(input int i);
        return (i == 1) ? 8 : 16;
    endfunction

    function automatic int depth_of(input int i);
        return (i == 2) ? 4 : 32;
    endfunction

    function automatic longint fib(input int n);
        longint x = 0, y = 1, t;
        for (int k = 0; k < n; k++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic longint res_of(input int i);
        case (i)
            0:       return longint'(r0);
            1:       return longint'(r1);
            default: return longint'(r2);
        endcase
    endfunction

    function automatic longint md_of(input int i);
        case (i)
            0:       return longint'(m0);
            1:       return longint'(m1);
            default: return longint'(m2);
        endcase
    endfunction

    task automatic chk(input string nm, input int i, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s [dut%0d] at %0t: got %0d, expected %0d", nm, i, $time, act, exp);
        end
    endtask

    task automatic model_accept(input int i, input int n);
        longint m = longint'(1) << res_w_of(i);
        longint f;
        bit     err = (n >= 2) && (n - 1 > depth_of(i));
        f = err ? 0 : fib(n);
        p_err[i] = err;
        p_res[i] = f % m;
        p_ovf[i] = !err && (f >= m);
        p_md[i]  = err ? depth_of(i) : ((n >= 2) ? n - 1 : 0);
        m_lat[i] = err ? depth_of(i) + 2 : int'(2 * (2 * fib(n + 1) - 1) + 1);
        m_ovf[i] = 0;
        m_err[i] = 0;
        m_md[i]  = 0;
        m_cnt[i] = 1;
        m_st[i]  = 1;
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_st[i] = 0; m_cnt[i] = 0; m_lat[i] = 0;
                m_res[i] = 0; m_ovf[i] = 0; m_err[i] = 0; m_md[i] = 0;
            end else if (m_st[i] == 0) begin
                if (start[i]) model_accept(i, int'(nin[i]));
            end else begin
                m_cnt[i]++;
                if (m_cnt[i] == m_lat[i]) begin
                    m_res[i] = p_res[i]; m_ovf[i] = p_ovf[i];
                    m_err[i] = p_err[i]; m_md[i]  = p_md[i];
                end else if (m_cnt[i] > m_lat[i]) begin
                    m_st[i] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit running, dn;
        for (int i = 0; i < 3; i++) begin
            running = (m_st[i] == 1) && (m_cnt[i] < m_lat[i]);
            dn      = (m_st[i] == 1) && (m_cnt[i] == m_lat[i]);
            chk("busy", i, longint'(busy_v[i]), longint'(running));
            chk("done", i, longint'(done_v[i]), longint'(dn));
            chk("result", i, res_of(i), m_res[i]);
            chk("stack_err", i, longint'(err_v[i]), running ? 0 : m_err[i]);
            if (!running) begin
                chk("ovf", i, longint'(ovf_v[i]), m_ovf[i]);
                chk("max_depth", i, md_of(i), m_md[i]);
            end
        end
    endtask

    task automatic start_run(input int i, input int n);
        @(negedge clk);
        nin[i]   = n[7:0];
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    // Entered on the first negedge after the accepting edge (cycle 1).
    task automatic wait_done(input int i, output int cyc);
        cyc = 1;
        while (!done_v[i] && cyc < 60000) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", i, longint'(done_v[i]), 1);
    endtask

    task automatic run(input int i, input int n, input int xr, input int xl,
                       input int xmd, input int xovf, input int xerr);
        int c;
        start_run(i, n);
        wait_done(i, c);
        if (xr >= 0) begin
            chk("lit_result", i, res_of(i), xr);
            chk("lit_latency", i, c, xl);
            chk("lit_max_depth", i, md_of(i), xmd);
            chk("lit_ovf", i, longint'(ovf_v[i]), xovf);
            chk("lit_stack_err", i, longint'(err_v[i]), xerr);
        end
    endtask

    initial begin
        int c, extra;
        rst_n = 1'b0;
        start = '0;
        for (int i = 0; i < 3; i++) begin
            nin[i] = '0; m_st[i] = 0; m_cnt[i] = 0; m_lat[i] = 0;
            m_res[i] = 0; m_ovf[i] = 0; m_err[i] = 0; m_md[i] = 0;
        end
        fork
            forever begin @(posedge clk); model_step(); end
            forever begin @(negedge clk); compare_all(); end
        join_none

        // Model sanity pins.
        chk("model_fib20", 0, fib(20), 6765);
        chk("model_fib14", 0, fib(14), 377);

        repeat (2) @(negedge clk);
        chk("rst_result", 0, res_of(0), 0);
        chk("rst_busy", 0, longint'(busy_v[0]), 0);
        rst_n = 1'b1;

        // Reset in the middle of a run abandons it.
        start_run(0, 10);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t1_busy", 0, longint'(busy_v[0]), 0);
        chk("t1_done", 0, longint'(done_v[0]), 0);
        chk("t1_result", 0, res_of(0), 0);
        chk("t1_max_depth", 0, md_of(0), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        run(0, 3, 2, 11, 2, 0, 0);

        // Base cases, latency and sweep.
        run(0, 0, 0, 3, 0, 0, 0);
        run(0, 1, 1, 3, 0, 0, 0);
        run(0, 2, 1, 7, 1, 0, 0);
        run(0, 5, 5, 31, 4, 0, 0);
        for (int n = 0; n <= 17; n++) run(0, n, -1, 0, 0, 0, 0);
        run(0, 20, 6765, 43783, 19, 0, 0);

        // Result wrap with an 8-bit datapath.
        run(1, 14, 121, 2439, 13, 1, 0);
        run(1, 13, 233, 1507, 12, 0, 0);

        // Stack bound at depth 4.
        run(2, 5, 5, 31, 4, 0, 0);
        run(2, 6, 0, 6, 4, 0, 1);
        run(2, 3, 2, 11, 2, 0, 0);

        // start held through the whole run and the DONE cycle.
        @(negedge clk);
        nin[0] = 8'd4;
        start[0] = 1'b1;
        @(negedge clk);
        wait_done(0, c);
        chk("t6_latency", 0, c, 19);
        chk("t6_result", 0, res_of(0), 3);
        @(negedge clk);
        start[0] = 1'b0;
        extra = 0;
        repeat (25) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) extra++;
        end
        chk("t6_single_run", 0, extra, 0);

        // start pulse while busy is ignored.
        start_run(0, 6);
        repeat (5) @(negedge clk);
        nin[0] = 8'd2;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, c);
        chk("t6_ignored_result", 0, res_of(0), 8);
        chk("t6_ignored_depth", 0, md_of(0), 5);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
